pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Multi-cycle fetch/decode/execute sequencer that owns the program counter for the RV32I core. It fetches each instruction from instruction memory over a request/valid handshake and holds it stable in InstOut for the immediate generator and decoder. It then selects the next PC using the generated immediate (ImmIn) and the branch outcome. It also detects fetch timeouts and misaligned targets, and halts on either.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FETCH_TIMEOUT, 15, maximum wait cycles in FETCH for ImemValid before error (range 1..255).

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
ImemReq  output  1  fetch request; held high while in FETCH
ImemAddr  output  32  fetch address; equals PcOut
ImemValid  input  1  instruction-memory data valid; sampled only in FETCH
ImemData  input  32  instruction word; captured when ImemReq && ImemValid
InstOut  output  32  registered current instruction, to immediate generator and decoder
ImmIn  input  32  sign-extended immediate produced from InstOut
BranchTaken  input  1  branch comparison result, sampled in EXEC
Stall  input  1  hold request from datapath, honoured in EXEC only
InstValid  output  1  high during EXEC cycles; enables register/memory writes
PcOut  output  32  current instruction PC
LinkPc  output  32  PcOut + 4 (jal link value), combinational from PC register
Halted  output  1  high in HALT state
ErrCode  output  2  00 none, 01 fetch timeout, 10 misaligned target; sticky until reset
RetireCnt  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=RESET, PC=RESET_PC, InstOut=32'h0000_0013 (nop), ImemReq=0, InstValid=0, Halted=0, ErrCode=00, timeout counter=0, RetireCnt=0.
- Release is synchronous in effect: the first clk edge with rst_n=1 moves RESET->FETCH.
- States are RESET, FETCH, DECODE, EXEC, HALT.
- FETCH:
  - ImemReq=1.
  - On ImemValid=1: latch ImemData into InstOut, clear the counter, go to DECODE.
  - Otherwise increment the counter. When the counter reaches FETCH_TIMEOUT with no valid, set ErrCode=01 and go to HALT.
  - Minimum fetch latency: 1 cycle (valid in the same cycle as req).
- DECODE: exactly one cycle; InstOut is stable so ImmIn can settle; no outputs change.
- EXEC:
  - InstValid=1.
  - If Stall=1: remain in EXEC; PC and InstOut held; InstValid stays 1.
  - If Stall=0: compute the next PC from opcode InstOut[6:0]:
    - 1101111 (jal): PC+ImmIn
    - 1100011 (branch) with BranchTaken=1: PC+ImmIn
    - anything else: PC+4
  - Additions are modulo 2^32; wrap-around is permitted.
  - If next_pc[1:0]!=00: ErrCode=10, PC unchanged, go to HALT.
  - Otherwise PC<=next_pc, RetireCnt++, go to FETCH.
- HALT: ImemReq=0, InstValid=0, Halted=1; exits only via reset.
- ImemValid outside FETCH is ignored.
- Stall outside EXEC is ignored.
- Reset asserted mid-fetch or mid-EXEC aborts immediately; nothing retires.
- Throughput without stalls: 3 cycles/instruction with a 1-cycle memory.

Optional Feature:
Macro RETIRE_CNT_EN.
- Defined: RetireCnt is a 32-bit counter incremented once per retired instruction (EXEC exit to FETCH). It wraps from 32'hFFFF_FFFF to 0 and resets to 0.
- Not defined: no counter logic is synthesised; RetireCnt is tied to 32'h0.

Test Plan:
- Reset, RESET_PC=0, memory returns 32'h00000013 with 1-cycle valid -> ImemAddr sequence 0,4,8; InstValid pulses every 3 cycles; RetireCnt=3 after third EXEC (RETIRE_CNT_EN defined).
- At PC=0x10, jal with ImmIn=32'hFFFF_FFF8 -> next ImemAddr=0x08, LinkPc=0x14 during EXEC.
- beq at PC=0x20, ImmIn=0x40: BranchTaken=1 -> ImemAddr=0x60; repeat with BranchTaken=0 -> 0x24.
- Stall held 4 cycles in EXEC -> InstValid high 5 cycles, PC unchanged, single retire.
- ImemValid never asserted, FETCH_TIMEOUT=15 -> Halted=1 and ErrCode=01 after 15 FETCH cycles; ImemReq drops; later ImemValid ignored.
- Branch taken with ImmIn=0x6 at PC=0x0 -> ErrCode=10, Halted=1, PcOut stays 0x0; rst_n pulse low mid-HALT -> PcOut=RESET_PC, ErrCode=00.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/decode/execute sequencer owning the RV32I
// program counter. Fetches over a req/valid handshake, holds the instruction
// for the immediate generator and decoder, then selects the next PC from the
// immediate and branch outcome. Halts on fetch timeout or misaligned target.
//
// Optional feature: define RETIRE_CNT_EN to build the 32-bit retired
// instruction counter; otherwise RetireCnt is tied to zero.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemValid,
    input  logic [31:0] ImemData,
    output logic [31:0] InstOut,
    input  logic [31:0] ImmIn,
    input  logic        BranchTaken,
    input  logic        Stall,
    output logic        InstValid,
    output logic [31:0] PcOut,
    output logic [31:0] LinkPc,
    output logic        Halted,
    output logic [1:0]  ErrCode,
    output logic [31:0] RetireCnt
);

    localparam logic [6:0]  OP_JAL        = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH     = 7'b1100011;
    localparam logic [31:0] NOP_INST      = 32'h0000_0013;
    localparam logic [7:0]  TIMEOUT_LIMIT = 8'(FETCH_TIMEOUT);
    localparam logic [1:0]  ERR_NONE      = 2'b00;
    localparam logic [1:0]  ERR_TIMEOUT   = 2'b01;
    localparam logic [1:0]  ERR_MISALIGN  = 2'b10;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  err;
    logic [7:0]  tmo_cnt;

    logic [6:0]  opcode;
    logic        take_target;
    logic [31:0] next_pc;
    logic        misaligned;
    logic [7:0]  tmo_next;
    logic        tmo_expired;
    logic        fetch_done;
    logic        exec_leave;
    logic        retire;

    // Next-PC selection and event decode shared by the FSM and the datapath.
    always_comb begin
        opcode      = inst[6:0];
        take_target = (opcode == OP_JAL) || ((opcode == OP_BRANCH) && BranchTaken);
        next_pc     = take_target ? (pc + ImmIn) : (pc + 32'd4);
        misaligned  = (next_pc[1:0] != 2'b00);
        tmo_next    = tmo_cnt + 8'd1;
        tmo_expired = (tmo_next == TIMEOUT_LIMIT);
        fetch_done  = (state == ST_FETCH) && ImemValid;
        exec_leave  = (state == ST_EXEC) && !Stall;
        retire      = exec_leave && !misaligned;
    end

    // State register; reset forces RESET and release moves on at the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived control outputs.
    always_comb begin
        state_next = state;
        ImemReq    = 1'b0;
        InstValid  = 1'b0;
        Halted     = 1'b0;
        case (state)
            ST_RESET: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                ImemReq = 1'b1;
                if (ImemValid) begin
                    state_next = ST_DECODE;
                end else if (tmo_expired) begin
                    state_next = ST_HALT;
                end
            end
            ST_DECODE: begin
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                InstValid = 1'b1;
                if (!Stall) begin
                    state_next = misaligned ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                Halted = 1'b1;
            end
            default: begin
                state_next = ST_HALT;
            end
        endcase
    end

    // Datapath: PC, captured instruction, sticky error code and fetch timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            inst    <= NOP_INST;
            err     <= ERR_NONE;
            tmo_cnt <= 8'd0;
        end else begin
            if (fetch_done) begin
                inst    <= ImemData;
                tmo_cnt <= 8'd0;
            end else if (state == ST_FETCH) begin
                tmo_cnt <= tmo_next;
                if (tmo_expired) begin
                    err <= ERR_TIMEOUT;
                end
            end
            if (retire) begin
                pc <= next_pc;
            end else if (exec_leave) begin
                err <= ERR_MISALIGN;
            end
        end
    end

`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt;

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= 32'd0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign RetireCnt = retire_cnt;
`else
    assign RetireCnt = 32'h0;
`endif

    assign ImemAddr = pc;
    assign PcOut    = pc;
    assign LinkPc   = pc + 32'd4;
    assign InstOut  = inst;
    assign ErrCode  = err;

endmodule
